serial_sub: RTL and testbench

//  Bit-serial WIDTH-bit subtractor: d = x - y - b_in, one bit per clock, LSB first.
//  The complement datapath to the ripple-carry adder family: one full-subtractor cell plus a borrow flop.

---
 rtl/serial_sub_pkg.sv | 21 ++
 rtl/serial_sub_full_sub.sv | 16 +
 rtl/serial_sub.sv | 99 +++++++++
 tb/tb_serial_sub.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared constants for bit-serial datapath blocks
package serial_sub_pkg;

    // Control states shared by the serial datapath family
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEFAULT = 4;

    // Bit counter width, wide enough to hold WIDTH itself
    localparam int CNT_W = $clog2(WIDTH_DEFAULT + 1);

    // Same counter width rule, for blocks built at a non-default width
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// rtl/serial_sub_full_sub.sv - single-bit full-subtractor cell
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic diff,
    output logic bout
);

    // Borrow is generated when a cannot cover b plus the incoming borrow
    always_comb begin
        diff = a ^ b ^ bi;
        bout = (~a & b) | (~a & bi) | (b & bi);
    end

endmodule

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor, LSB first, start/busy/done handshake
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             ovf
);

    localparam int                CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]     LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] xs_q, ys_q, d_q;
    logic             borrow_q, b_out_q, ovf_q;
    logic             cell_diff, cell_bout;
    logic             accept, last_bit;

    // Busy is exactly "not idle", so acceptance only happens from IDLE
    assign accept   = (state_q == ST_IDLE) && start;
    assign last_bit = (state_q == ST_RUN) && (cnt_q == LAST_BIT);

    full_sub u_cell (
        .a    (xs_q[0]),
        .b    (ys_q[0]),
        .bi   (borrow_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // State register; reset aborts any operation without a done pulse
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state: IDLE -> RUN on accept, RUN for WIDTH cycles, one DONE cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (state_q != ST_IDLE);
        done = (state_q == ST_DONE);
    end

    // Datapath: operand capture, one cell step per RUN cycle, flags on the final bit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            xs_q     <= '0;
            ys_q     <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            xs_q     <= x;
            ys_q     <= y;
            borrow_q <= b_in;
            cnt_q    <= '0;
        end else if (state_q == ST_RUN) begin
            xs_q     <= xs_q >> 1;
            ys_q     <= ys_q >> 1;
            d_q      <= {cell_diff, d_q[WIDTH-1:1]};
            borrow_q <= cell_bout;
            cnt_q    <= cnt_q + CW'(1);
            if (last_bit) begin
                // On the MSB step the cell inputs are the operand sign bits
                // and its diff is the result sign bit.
                b_out_q <= cell_bout;
                ovf_q   <= (xs_q[0] != ys_q[0]) && (cell_diff != xs_q[0]);
            end
        end
    end

    assign d     = d_q;
    assign b_out = b_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - directed and exhaustive checks for serial_sub at WIDTH=4
module tb_serial_sub;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] x, y;
    logic         b_in;
    logic         busy, done, b_out, ovf;
    logic [W-1:0] d;

    int n_vec = 0;
    int n_err = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b_out (b_out),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for done from the negedge where start was raised; returns latency in cycles
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Full operation with reference results computed from plain arithmetic
    task automatic run_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] ya,
                          input logic ba, input bit check_lat);
        int          lat;
        logic [W:0]  full;
        logic [W-1:0] de;
        logic        oe;
        full = {1'b0, xa} - {1'b0, ya} - {{W{1'b0}}, ba};
        de   = full[W-1:0];
        oe   = (xa[W-1] != ya[W-1]) && (de[W-1] != xa[W-1]);
        @(negedge clk);
        start = 1'b1; x = xa; y = ya; b_in = ba;
        wait_done(tag, lat);
        if (check_lat) chk({tag, "_lat"}, lat, W + 1);
        chk({tag, "_d"},    d,     de);
        chk({tag, "_bout"}, b_out, full[W]);
        chk({tag, "_ovf"},  ovf,   oe);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        rst = 1'b1; start = 1'b0; x = '0; y = '0; b_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_d", d, 0);
        chk("rst_bout", b_out, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;

        // 1: basic op, latency and busy window
        @(negedge clk);
        start = 1'b1; x = 4'd7; y = 4'd3; b_in = 1'b0;
        busy_cnt = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin lat = i; break; end
        end
        chk("t1_lat", lat, 5);
        chk("t1_busy_cycles", busy_cnt, 5);
        chk("t1_d", d, 4);
        chk("t1_bout", b_out, 0);
        chk("t1_ovf", ovf, 0);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_d_hold", d, 4);

        // 2: borrows
        run_op("t2a", 4'd3, 4'd5, 1'b0, 1'b1);
        chk("t2a_d_lit", d, 4'b1110);
        run_op("t2b", 4'd0, 4'd0, 1'b1, 1'b1);
        chk("t2b_d_lit", d, 4'hF);

        // 3: signed overflow
        run_op("t3a", 4'b0111, 4'b1000, 1'b0, 1'b1);
        chk("t3a_ovf_lit", ovf, 1);
        run_op("t3b", 4'd8, 4'd1, 1'b0, 1'b1);
        chk("t3b_d_lit", d, 7);

        // 4: starts during RUN and DONE ignored, start right after DONE accepted
        @(negedge clk);
        start = 1'b1; x = 4'd7; y = 4'd3; b_in = 1'b0;
        @(negedge clk);                        // RUN1
        start = 1'b0;
        @(negedge clk);                        // RUN2
        start = 1'b1; x = 4'd1; y = 4'd2;
        @(negedge clk);                        // RUN3
        start = 1'b0; x = 4'd5; y = 4'd5;
        @(negedge clk);                        // RUN4
        @(negedge clk);                        // DONE
        chk("t4_done", done, 1);
        chk("t4_d", d, 4);
        chk("t4_bout", b_out, 0);
        start = 1'b1; x = 4'd2; y = 4'd1;
        @(negedge clk);                        // IDLE
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_done", done, 0);
        chk("t4_idle_d", d, 4);
        start = 1'b1; x = 4'd9; y = 4'd2; b_in = 1'b1;
        wait_done("t4b", lat);
        chk("t4b_lat", lat, 5);
        chk("t4b_d", d, 6);
        chk("t4b_bout", b_out, 0);
        chk("t4b_ovf", ovf, 1);

        // 5: reset mid-operation, then reset with start
        run_op("t5pre", 4'd3, 4'd5, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; x = 4'd9; y = 4'd3; b_in = 1'b0;
        @(negedge clk);                        // RUN1
        start = 1'b0;
        @(negedge clk);                        // RUN2
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_d", d, 0);
        chk("t5_bout", b_out, 0);
        busy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) busy_cnt++;
            @(negedge clk);
        end
        chk("t5_no_done", busy_cnt, 0);
        rst = 1'b1; start = 1'b1; x = 4'd5; y = 4'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("t5_rst_start_busy", busy, 0);
        @(negedge clk);
        chk("t5_rst_start_busy2", busy, 0);

        // 6: exhaustive over all operand combinations
        for (int bb = 0; bb < 2; bb++)
            for (int xi = 0; xi < 16; xi++)
                for (int yi = 0; yi < 16; yi++)
                    run_op("ex", W'(xi), W'(yi), bb[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
